// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL lock qualification and sequenced reset release
//
// Waits for a stable synchronised PLL lock, then releases NUM_STAGES
// active-low resets one after another, STAGE_GAP cycles apart.
// Optional lock watchdog: define PLL_RST_SEQ_WDOG_EN.
//
// Ports:
//   clk           - PLL reference clock, rising edge
//   resetn        - asynchronous active-low reset
//   pll_lock      - raw PLL lock, asynchronous to clk
//   sw_rst_req    - single-cycle software reset request
//   rst_n_out     - sequenced active-low resets, bit 0 released first
//   ready         - high only in RUN
//   pll_reset     - active-high pulse to the PLL RESET pin
//   lock_loss_cnt - saturating count of lock losses after release

module pll_rst_seq #(
    parameter int NUM_STAGES    = 3,
    parameter int STABLE_CYCLES = 1024,
    parameter int STAGE_GAP     = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int PLL_RST_PULSE = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pll_lock,
    input  logic                  sw_rst_req,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  ready,
    output logic                  pll_reset,
    output logic [7:0]            lock_loss_cnt
);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        PLL_RST
    } state_t;

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [SW-1:0]         STAB_LAST   = SW'(STABLE_CYCLES - 1);
    localparam logic [GW-1:0]         GAP_LAST    = GW'(STAGE_GAP - 1);
    localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

    logic                  lock_meta;
    logic                  lock_s;
    state_t                state_q, state_d;
    logic [SW-1:0]         stab_cnt_q, stab_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d, rst_n_shift;
    logic                  ready_q, ready_d;
    logic [7:0]            loss_q, loss_d;
    logic                  abort;
    logic                  lost;
    logic                  wdog_fire;
    logic                  pulse_done;

    // Next stage released by shifting a one in from the bottom.
    assign rst_n_shift = NUM_STAGES'({rst_n_q, 1'b1});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rst_n_d    = rst_n_q;
        ready_d    = ready_q;
        loss_d     = loss_q;
        abort      = 1'b0;
        lost       = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                rst_n_d = '0;
                ready_d = 1'b0;
                if (wdog_fire) begin
                    state_d = PLL_RST;
                end else if (lock_s) begin
                    state_d    = STABLE;
                    stab_cnt_d = '0;
                end
            end
            STABLE: begin
                // A lock drop before release is not a loss.
                if (wdog_fire) begin
                    state_d = PLL_RST;
                end else if (!lock_s || sw_rst_req) begin
                    abort = 1'b1;
                end else if (stab_cnt_q == STAB_LAST) begin
                    gap_cnt_d = '0;
                    rst_n_d   = FIRST_STAGE;
                    if (&FIRST_STAGE) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s || sw_rst_req) begin
                    abort = 1'b1;
                    lost  = !lock_s;
                end else if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    rst_n_d   = rst_n_shift;
                    if (&rst_n_shift) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s || sw_rst_req) begin
                    abort = 1'b1;
                    lost  = !lock_s;
                end
            end
            PLL_RST: begin
                if (pulse_done) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        if (abort) begin
            state_d = WAIT_LOCK;
            rst_n_d = '0;
            ready_d = 1'b0;
            if (lost && loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= WAIT_LOCK;
            stab_cnt_q <= '0;
            gap_cnt_q  <= '0;
            rst_n_q    <= '0;
            ready_q    <= 1'b0;
            loss_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            rst_n_q    <= rst_n_d;
            ready_q    <= ready_d;
            loss_q     <= loss_d;
        end
    end

    assign rst_n_out     = rst_n_q;
    assign ready         = ready_q;
    assign lock_loss_cnt = loss_q;

`ifdef PLL_RST_SEQ_WDOG_EN
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int PW = (PLL_RST_PULSE > 1) ? $clog2(PLL_RST_PULSE) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [PW-1:0] PULSE_LAST   = PW'(PLL_RST_PULSE - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pulse_q, pulse_d;
    logic          pll_reset_q;
    logic          hunt_now;
    logic          hunt_next;

    // The timer only accumulates while staying inside WAIT_LOCK/STABLE;
    // any other transition (release, PLL_RST, return from PLL_RST) zeroes it.
    always_comb begin
        hunt_now  = (state_q == WAIT_LOCK) || (state_q == STABLE);
        hunt_next = (state_d == WAIT_LOCK) || (state_d == STABLE);
        timer_d   = (hunt_now && hunt_next) ? timer_q + 1'b1 : '0;
        pulse_d   = (state_q == PLL_RST && state_d == PLL_RST) ? pulse_q + 1'b1 : '0;
    end

    assign wdog_fire  = ((state_q == WAIT_LOCK) || (state_q == STABLE)) && (timer_q == TIMEOUT_LAST);
    assign pulse_done = (pulse_q == PULSE_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q     <= '0;
            pulse_q     <= '0;
            pll_reset_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            pulse_q     <= pulse_d;
            pll_reset_q <= (state_d == PLL_RST);
        end
    end

    assign pll_reset = pll_reset_q;
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = ^{LOCK_TIMEOUT, PLL_RST_PULSE};
    assign wdog_fire       = 1'b0;
    // PLL_RST is never entered; if it somehow were, leave it at once.
    assign pulse_done      = 1'b1;
    assign pll_reset       = 1'b0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - scoreboard bench for pll_rst_seq

module tb_pll_rst_seq;

    localparam int NS    = 3;
    localparam int SC    = 8;
    localparam int GAP   = 4;
    localparam int LT    = 64;
    localparam int PULSE = 16;

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic          pll_lock   = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic [NS-1:0] rst_n_out;
    logic          ready;
    logic          pll_reset;
    logic [7:0]    lock_loss_cnt;

    typedef struct {
        int         cyc;
        logic [4:0] val;
    } evt_t;

    evt_t       exp_q[$];
    int         n_cmp    = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    bit         mon_en   = 1'b1;
    logic [4:0] prev_vec = '0;

    pll_rst_seq #(
        .NUM_STAGES    (NS),
        .STABLE_CYCLES (SC),
        .STAGE_GAP     (GAP),
        .LOCK_TIMEOUT  (LT),
        .PLL_RST_PULSE (PULSE)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pll_lock      (pll_lock),
        .sw_rst_req    (sw_rst_req),
        .rst_n_out     (rst_n_out),
        .ready         (ready),
        .pll_reset     (pll_reset),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_evt(input int c, input logic [4:0] v);
        evt_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    // r0 is the edge on which rst_n_out[0] is expected to rise.
    task automatic push_release(input int r0);
        logic [NS-1:0] bits;
        bits = '0;
        for (int k = 0; k < NS; k++) begin
            bits[k] = 1'b1;
            push_evt(r0 + k * GAP, {1'b0, (k == NS - 1), bits});
        end
    endtask

    // Every change of {pll_reset, ready, rst_n_out} must match the head of the queue.
    always @(posedge clk) begin
        logic [4:0] cur;
        evt_t       e;
        #1;
        cur = {pll_reset, ready, rst_n_out};
        if (mon_en && cur !== prev_vec) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", 32'(cur), 32'(prev_vec));
            end else begin
                e = exp_q.pop_front();
                check("evt_edge", cyc, e.cyc);
                check("evt_value", 32'(cur), 32'(e.val));
            end
        end
        prev_vec = cur;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int e0;
        int d;
        int a;
        int g;

        #2;
        check("reset_rst_n_out", rst_n_out, 0);
        check("reset_ready", ready, 0);
        check("reset_pll_reset", pll_reset, 0);
        check("reset_loss_cnt", lock_loss_cnt, 0);

        // Lock held low from reset.
        @(negedge clk);
        resetn = 1'b1;
        c = cyc;
`ifdef PLL_RST_SEQ_WDOG_EN
        push_evt(c + LT, 5'b10000);
        push_evt(c + LT + PULSE, 5'b00000);
        push_evt(c + 2 * LT + PULSE, 5'b10000);
        push_evt(c + 2 * (LT + PULSE), 5'b00000);
`endif
        repeat (170) @(negedge clk);
        check("wdog_drain", exp_q.size(), 0);
        check("wdog_pll_reset_idle", pll_reset, 0);
        check("wdog_rst_n_out", rst_n_out, 0);

        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Clean lock.
        pll_lock = 1'b1;
        e0 = cyc + 1;
        push_release(e0 + 2 + SC);
        repeat (25) @(negedge clk);
        check("clean_ready", ready, 1);
        check("clean_loss_cnt", lock_loss_cnt, 0);
        check("clean_drain", exp_q.size(), 0);

        // Lock loss in RUN, then re-lock.
        pll_lock = 1'b0;
        d = cyc + 1;
        push_evt(d + 2, 5'b00000);
        repeat (5) @(negedge clk);
        check("loss_cnt_1", lock_loss_cnt, 1);
        pll_lock = 1'b1;
        e0 = cyc + 1;
        push_release(e0 + 2 + SC);
        repeat (25) @(negedge clk);
        check("relock_drain", exp_q.size(), 0);

        // Software reset in RUN.
        sw_rst_req = 1'b1;
        a = cyc + 1;
        push_evt(a, 5'b00000);
        push_release(a + 1 + SC);
        @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (24) @(negedge clk);
        check("sw_loss_cnt", lock_loss_cnt, 1);
        check("sw_drain", exp_q.size(), 0);

        // Glitch during STABLE.
        pll_lock = 1'b0;
        d = cyc + 1;
        push_evt(d + 2, 5'b00000);
        repeat (5) @(negedge clk);
        check("loss_cnt_2", lock_loss_cnt, 2);
        pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        pll_lock = 1'b1;
        g = cyc + 1;
        push_release(g + 2 + SC);
        repeat (25) @(negedge clk);
        check("glitch_loss_cnt", lock_loss_cnt, 2);
        check("glitch_drain", exp_q.size(), 0);

        // Lock loss and sw_rst_req seen on the same edge.
        pll_lock = 1'b0;
        d = cyc + 1;
        push_evt(d + 2, 5'b00000);
        repeat (2) @(negedge clk);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        check("same_cycle_loss_cnt", lock_loss_cnt, 3);
        check("same_cycle_drain", exp_q.size(), 0);

        // Saturation: 300 further losses from RELEASE.
        mon_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b1;
            repeat (12) @(negedge clk);
            pll_lock = 1'b0;
            repeat (4) @(negedge clk);
            if (i == 99) check("loss_cnt_103", lock_loss_cnt, 103);
        end
        check("loss_cnt_sat", lock_loss_cnt, 255);
        mon_en = 1'b1;

        // resetn asserted mid-RELEASE.
        pll_lock = 1'b1;
        e0 = cyc + 1;
        push_evt(e0 + 2 + SC, 5'b00001);
        push_evt(e0 + 12, 5'b00000);
        repeat (12) @(negedge clk);
        check("mid_release_rst0", rst_n_out, 1);
        resetn = 1'b0;
        #2;
        check("async_rst_n_out", rst_n_out, 0);
        check("async_ready", ready, 0);
        check("async_pll_reset", pll_reset, 0);
        check("async_loss_cnt", lock_loss_cnt, 0);
        repeat (3) @(negedge clk);
        check("held_rst_n_out", rst_n_out, 0);
        resetn = 1'b1;
        e0 = cyc + 1;
        push_release(e0 + 2 + SC);
        repeat (25) @(negedge clk);
        check("post_reset_ready", ready, 1);
        check("post_reset_loss_cnt", lock_loss_cnt, 0);
        check("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
